icache_load_ctrl: RTL and testbench
===================================

ICACHE_LOAD_CTRL -- requirements
Module: icache_load_ctrl

Interface
REQ-001 Parameter WORDS, default 128, instruction memory depth in 32-bit words.
REQ-002 Parameter LENW, default 8, width of the load-length field; SHALL satisfy 2^LENW > WORDS.
REQ-003 PHI1  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 MRST  input  1  reset, asynchronous, active-low.
REQ-005 LdStart  input  1  one-cycle request to begin a program load.
REQ-006 LdLen  input  LENW  word count of the load, sampled with LdStart.
REQ-007 LdSum  input  32  expected checksum, sampled with LdStart; used only under ICACHE_LOAD_CHKSUM_EN.
REQ-008 LdData  input  32  program word from host.
REQ-009 LdValid  input  1  LdData valid.
REQ-010 LdReady  output  1  controller accepts LdData.
REQ-011 IAddrE  output  32  word index written into instruction memory.
REQ-012 IInE  output  32  word written into instruction memory.
REQ-013 IWriteE  output  1  instruction-memory write strobe.
REQ-014 CoreRun  output  1  drives the instruction memory's run/reset input; 1 = core fetches.
REQ-015 LdBusy  output  1  load in progress.
REQ-016 LdDone  output  1  one-cycle pulse on successful load completion.
REQ-017 LdErr  output  1  level; load rejected or failed.

Function
REQ-018 States SHALL be IDLE, LOAD, FLUSH, RUN, ERR; the state register SHALL be binary-encoded.
REQ-019 IDLE: CoreRun=0, LdReady=0; LdStart with 1<=LdLen<=WORDS -> LOAD; LdStart with LdLen=0 or LdLen>WORDS -> ERR.
REQ-020 On entering LOAD, the word counter SHALL be cleared and LdLen latched.
REQ-021 LOAD: LdReady=1, LdBusy=1, CoreRun=0; a beat is accepted when LdValid&&LdReady at a rising edge.
REQ-022 For each accepted beat, IInE=LdData, IAddrE=counter (zero-extended), and IWriteE=1 SHALL be registered for exactly the following cycle; the counter SHALL then increment by 1.
REQ-023 All outputs SHALL be registered so IAddrE/IInE/IWriteE are stable at the falling edge of PHI1, when the memory samples them.
REQ-024 The beat that makes counter equal to the latched LdLen SHALL move the state to FLUSH; LdReady SHALL be 0 in FLUSH.
REQ-025 FLUSH lasts one cycle, carries the final IWriteE, and then -> RUN (subject to REQ-033).
REQ-026 LdDone SHALL pulse for exactly one cycle on the FLUSH->RUN transition.
REQ-027 RUN: CoreRun=1, LdBusy=0, IWriteE=0; a valid LdStart -> LOAD with CoreRun=0 from the next cycle; an invalid LdStart -> ERR.
REQ-028 LdStart in LOAD or FLUSH SHALL be ignored.
REQ-029 LdValid gaps in LOAD SHALL stall without writes; IWriteE SHALL be 0 in any cycle following a non-accepted cycle.
REQ-030 ERR: LdErr=1, CoreRun=0; a valid LdStart -> LOAD and clears LdErr; otherwise ERR is held.
REQ-031 The counter SHALL never exceed WORDS-1 as an address; no write SHALL occur at an index >= latched LdLen.

Reset
REQ-032 While MRST=0: state=IDLE, counter=0, CoreRun=0, LdReady=0, IWriteE=0, IAddrE=0, IInE=0, LdBusy=0, LdDone=0, LdErr=0; asserting MRST mid-load SHALL abort the load immediately with no further writes.

Configuration
REQ-033 With ICACHE_LOAD_CHKSUM_EN defined, a 32-bit sum (mod 2^32) of the accepted words is accumulated, cleared on entering LOAD; in FLUSH, sum==latched LdSum -> RUN, otherwise -> ERR with no LdDone pulse.
REQ-034 Without ICACHE_LOAD_CHKSUM_EN, no accumulator exists, LdSum is ignored, and FLUSH always -> RUN.

Verification
REQ-035 Reset, then LdStart with LdLen=3, words 0x20210006,0x0,0xCC610005 back-to-back -> IWriteE at indices 0,1,2 on consecutive cycles, LdDone pulse one cycle after FLUSH, CoreRun=1.
REQ-036 LdLen=4 with LdValid toggling 1,0,1,0,... -> exactly 4 writes at indices 0..3, no writes in gap cycles.
REQ-037 LdStart with LdLen=0, then with LdLen=129 -> ERR, LdErr=1, CoreRun=0, no IWriteE; then LdLen=1 -> LOAD, LdErr=0.
REQ-038 In RUN, LdStart with LdLen=2 -> CoreRun drops next cycle, reload writes indices 0..1, CoreRun returns to 1.
REQ-039 MRST pulsed low after 2 of 5 beats -> all outputs at reset values, no further IWriteE.
REQ-040 With ICACHE_LOAD_CHKSUM_EN, LdLen=2, words 0x1,0x2: LdSum=0x3 -> RUN with LdDone; LdSum=0x4 -> ERR, no LdDone.

Source files
------------

// File: rtl/icache_load_ctrl_if.sv
// Host-side load port and instruction-memory write port of icache_load_ctrl.
// master = host/bench driving the load, slave = the load controller.
interface icache_load_ctrl_if #(
  parameter int LENW = 8
);
  logic            LdStart;
  logic [LENW-1:0] LdLen;
  logic [31:0]     LdSum;
  logic [31:0]     LdData;
  logic            LdValid;
  logic            LdReady;
  logic [31:0]     IAddrE;
  logic [31:0]     IInE;
  logic            IWriteE;
  logic            CoreRun;
  logic            LdBusy;
  logic            LdDone;
  logic            LdErr;

  modport master (
    output LdStart, LdLen, LdSum, LdData, LdValid,
    input  LdReady, IAddrE, IInE, IWriteE, CoreRun, LdBusy, LdDone, LdErr
  );

  modport slave (
    input  LdStart, LdLen, LdSum, LdData, LdValid,
    output LdReady, IAddrE, IInE, IWriteE, CoreRun, LdBusy, LdDone, LdErr
  );
endinterface

// File: rtl/icache_load_ctrl.sv
// Program loader: streams host words into instruction memory, then releases the core.
// Optional checksum verification of the loaded image: define ICACHE_LOAD_CHKSUM_EN.
module icache_load_ctrl #(
  parameter int WORDS = 128,
  parameter int LENW  = 8
) (
  input logic               PHI1,
  input logic               MRST,
  icache_load_ctrl_if.slave bus
);

  localparam logic [LENW-1:0] WORDS_L = LENW'(WORDS);
  localparam logic [LENW-1:0] ONE_L   = LENW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t          state_reg;
  logic [LENW-1:0] cnt_reg;
  logic [LENW-1:0] len_reg;
  logic [LENW-1:0] cnt_next;
  logic            ready_reg;
  logic            write_reg;
  logic            run_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            err_reg;
  logic [31:0]     addr_reg;
  logic [31:0]     data_reg;

  logic idle_like;
  logic len_ok;
  logic load_go;
  logic load_bad;
  logic accept;
  logic sum_ok;

  // A new load may only be requested from a settled state; LOAD/FLUSH ignore LdStart.
  assign idle_like = (state_reg == S_IDLE) || (state_reg == S_RUN) || (state_reg == S_ERR);
  assign len_ok    = (bus.LdLen != '0) && (bus.LdLen <= WORDS_L);
  assign load_go   = idle_like && bus.LdStart && len_ok;
  assign load_bad  = idle_like && bus.LdStart && !len_ok;
  assign accept    = (state_reg == S_LOAD) && bus.LdValid && ready_reg;
  assign cnt_next  = cnt_reg + ONE_L;

`ifdef ICACHE_LOAD_CHKSUM_EN
  logic [31:0] sum_reg;
  logic [31:0] sum_exp_reg;

  always_ff @(posedge PHI1 or negedge MRST) begin
    if (!MRST) begin
      sum_reg     <= '0;
      sum_exp_reg <= '0;
    end else if (load_go) begin
      sum_reg     <= '0;
      sum_exp_reg <= bus.LdSum;
    end else if (accept) begin
      sum_reg     <= sum_reg + bus.LdData;
    end
  end

  assign sum_ok = (sum_reg == sum_exp_reg);
`else
  logic unused_ldsum;
  assign unused_ldsum = ^bus.LdSum;
  assign sum_ok       = 1'b1;
`endif

  always_ff @(posedge PHI1 or negedge MRST) begin
    if (!MRST) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      len_reg   <= '0;
      ready_reg <= 1'b0;
      write_reg <= 1'b0;
      run_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      write_reg <= 1'b0;
      done_reg  <= 1'b0;
      case (state_reg)
        S_IDLE, S_RUN, S_ERR: begin
          if (load_go) begin
            state_reg <= S_LOAD;
            cnt_reg   <= '0;
            len_reg   <= bus.LdLen;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b1;
            run_reg   <= 1'b0;
            err_reg   <= 1'b0;
          end else if (load_bad) begin
            state_reg <= S_ERR;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b0;
            run_reg   <= 1'b0;
            err_reg   <= 1'b1;
          end
        end
        S_LOAD: begin
          if (accept) begin
            write_reg <= 1'b1;
            addr_reg  <= 32'(cnt_reg);
            data_reg  <= bus.LdData;
            cnt_reg   <= cnt_next;
            // Dropping ready with the last beat guarantees no write at index >= len.
            if (cnt_next == len_reg) begin
              state_reg <= S_FLUSH;
              ready_reg <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          busy_reg <= 1'b0;
          if (sum_ok) begin
            state_reg <= S_RUN;
            run_reg   <= 1'b1;
            done_reg  <= 1'b1;
          end else begin
            state_reg <= S_ERR;
            err_reg   <= 1'b1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          ready_reg <= 1'b0;
          busy_reg  <= 1'b0;
          run_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.LdReady = ready_reg;
  assign bus.IAddrE  = addr_reg;
  assign bus.IInE    = data_reg;
  assign bus.IWriteE = write_reg;
  assign bus.CoreRun = run_reg;
  assign bus.LdBusy  = busy_reg;
  assign bus.LdDone  = done_reg;
  assign bus.LdErr   = err_reg;

endmodule

// File: tb/tb_icache_load_ctrl.sv
// Scoreboarded random bench for icache_load_ctrl: stimulus pushes expected writes,
// a negedge monitor pops and compares every memory write and counts LdDone pulses.
module tb_icache_load_ctrl;

  localparam int WORDS = 128;
  localparam int LENW  = 8;

  logic PHI1;
  logic MRST;

  icache_load_ctrl_if #(.LENW(LENW)) bus ();

  icache_load_ctrl #(.WORDS(WORDS), .LENW(LENW)) dut (
    .PHI1 (PHI1),
    .MRST (MRST),
    .bus  (bus)
  );

  initial PHI1 = 1'b0;
  always #5 PHI1 = ~PHI1;

  int          checks;
  int          errors;
  int          done_seen;
  logic [63:0] exp_wr_q[$];
  logic [31:0] wbuf[256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write the memory would sample must be the next expected one.
  always @(negedge PHI1) begin
    logic [63:0] e;
    if (bus.IWriteE === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write at %0t",
                 bus.IAddrE, bus.IInE, $time);
      end else begin
        e = exp_wr_q.pop_front();
        check("write_addr", bus.IAddrE, e[63:32]);
        check("write_data", bus.IInE, e[31:0]);
      end
    end
    if (bus.LdDone === 1'b1) done_seen++;
  end

  // Reference behaviour: a valid load writes wbuf[0..len-1] at indices 0..len-1 in order,
  // then runs (or errs on a bad checksum when checking is built in); invalid lengths err.
  task automatic do_load(input int len, input bit good_sum, input int gap_mode, input bit poke);
    logic [31:0] s;
    logic [31:0] lsum;
    bit          valid;
    bit          ok;
    int          base_done;
    int          gaps;
    valid = (len >= 1) && (len <= WORDS);
    s = 32'h0;
    if (valid) for (int i = 0; i < len; i++) s = s + wbuf[i];
    lsum = good_sum ? s : s + 32'd1 + 32'($urandom_range(0, 100));
`ifdef ICACHE_LOAD_CHKSUM_EN
    ok = valid && good_sum;
`else
    ok = valid;
`endif
    $display("load len=%0d gap_mode=%0d poke=%0d expect_run=%0d", len, gap_mode, poke, ok);
    base_done = done_seen;
    @(negedge PHI1);
    bus.LdStart = 1'b1;
    bus.LdLen   = LENW'(len);
    bus.LdSum   = lsum;
    bus.LdValid = 1'b0;
    @(negedge PHI1);
    bus.LdStart = 1'b0;
    if (!valid) begin
      @(negedge PHI1);
      check("bad_len_err", {31'b0, bus.LdErr}, 32'd1);
      check("bad_len_corerun", {31'b0, bus.CoreRun}, 32'd0);
      check("bad_len_busy", {31'b0, bus.LdBusy}, 32'd0);
      return;
    end
    check("start_ready", {31'b0, bus.LdReady}, 32'd1);
    check("start_busy", {31'b0, bus.LdBusy}, 32'd1);
    check("start_err_clear", {31'b0, bus.LdErr}, 32'd0);
    check("start_corerun", {31'b0, bus.CoreRun}, 32'd0);
    for (int i = 0; i < len; i++) begin
      gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? ((i > 0) ? 1 : 0) : $urandom_range(0, 2);
      repeat (gaps) begin
        bus.LdValid = 1'b0;
        bus.LdData  = $urandom;
        @(negedge PHI1);
      end
      bus.LdValid = 1'b1;
      bus.LdData  = wbuf[i];
      if (poke && (i == len / 2)) begin
        bus.LdStart = 1'b1;
        bus.LdLen   = LENW'($urandom_range(1, 5));
      end
      if (bus.LdReady !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL beat_ready: got %b expected 1 for beat %0d", bus.LdReady, i);
      end
      exp_wr_q.push_back({32'(i), wbuf[i]});
      @(negedge PHI1);
      bus.LdStart = 1'b0;
    end
    bus.LdValid = 1'b0;
    bus.LdData  = $urandom;
    repeat (2) @(negedge PHI1);
    check("end_corerun", {31'b0, bus.CoreRun}, {31'b0, ok});
    check("end_err", {31'b0, bus.LdErr}, {31'b0, !ok});
    check("end_busy", {31'b0, bus.LdBusy}, 32'd0);
    check("end_ready", {31'b0, bus.LdReady}, 32'd0);
    check("end_done_low", {31'b0, bus.LdDone}, 32'd0);
    check("done_pulses", 32'(done_seen - base_done), ok ? 32'd1 : 32'd0);
    check("writes_drained", 32'(exp_wr_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_corerun"}, {31'b0, bus.CoreRun}, 32'd0);
    check({tag, "_ready"}, {31'b0, bus.LdReady}, 32'd0);
    check({tag, "_write"}, {31'b0, bus.IWriteE}, 32'd0);
    check({tag, "_addr"}, bus.IAddrE, 32'd0);
    check({tag, "_data"}, bus.IInE, 32'd0);
    check({tag, "_busy"}, {31'b0, bus.LdBusy}, 32'd0);
    check({tag, "_done"}, {31'b0, bus.LdDone}, 32'd0);
    check({tag, "_err"}, {31'b0, bus.LdErr}, 32'd0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int len;
    int pick;
    checks      = 0;
    errors      = 0;
    done_seen   = 0;
    MRST        = 1'b0;
    bus.LdStart = 1'b0;
    bus.LdLen   = '0;
    bus.LdSum   = '0;
    bus.LdData  = '0;
    bus.LdValid = 1'b0;
    repeat (3) @(negedge PHI1);
    check_reset_outputs("reset");
    MRST = 1'b1;
    @(negedge PHI1);

    // Known three-word image, back-to-back beats.
    wbuf[0] = 32'h20210006; wbuf[1] = 32'h0; wbuf[2] = 32'hCC610005;
    do_load(3, 1'b1, 0, 1'b0);

    // Alternating valid.
    for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
    do_load(4, 1'b1, 1, 1'b0);

    // Bad lengths, then recovery from ERR.
    do_load(0, 1'b1, 0, 1'b0);
    do_load(129, 1'b1, 0, 1'b0);
    wbuf[0] = $urandom;
    do_load(1, 1'b1, 0, 1'b0);

    // Reload from RUN.
    wbuf[0] = $urandom; wbuf[1] = $urandom;
    do_load(2, 1'b1, 0, 1'b0);

    // Full-depth load and the first out-of-range length.
    for (int i = 0; i < WORDS; i++) wbuf[i] = $urandom;
    do_load(WORDS, 1'b1, 2, 1'b0);
    do_load(WORDS + 1, 1'b1, 0, 1'b0);

    // Checksum pair: right sum runs, wrong sum errs when checking is built in.
    wbuf[0] = 32'h1; wbuf[1] = 32'h2;
    do_load(2, 1'b1, 0, 1'b0);
    do_load(2, 1'b0, 0, 1'b0);

    // Randomized loads, including LdStart pokes mid-load that must be ignored.
    for (int r = 0; r < 16; r++) begin
      pick = $urandom_range(0, 9);
      len = (pick == 0) ? 0 : (pick == 1) ? $urandom_range(WORDS + 1, 255)
          : (pick == 2) ? WORDS : $urandom_range(1, 12);
      for (int i = 0; i < 256; i++) wbuf[i] = $urandom;
      do_load(len, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a five-word load: two writes, then nothing.
    $display("load len=5 aborted by reset after 2 beats");
    for (int i = 0; i < 5; i++) wbuf[i] = $urandom | 32'h1;
    @(negedge PHI1);
    bus.LdStart = 1'b1;
    bus.LdLen   = LENW'(5);
    @(negedge PHI1);
    bus.LdStart = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.LdValid = 1'b1;
      bus.LdData  = wbuf[i];
      exp_wr_q.push_back({32'(i), wbuf[i]});
      @(negedge PHI1);
    end
    bus.LdValid = 1'b0;
    @(negedge PHI1);
    #2 MRST = 1'b0;
    #1 check_reset_outputs("midload_reset");
    repeat (2) @(negedge PHI1);
    MRST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.LdValid = 1'b1;
      bus.LdData  = $urandom;
      @(negedge PHI1);
    end
    bus.LdValid = 1'b0;
    @(negedge PHI1);
    check("post_reset_ready", {31'b0, bus.LdReady}, 32'd0);
    check("post_reset_busy", {31'b0, bus.LdBusy}, 32'd0);
    check("post_reset_drained", 32'(exp_wr_q.size()), 32'd0);

    // Controller must still load normally after the abort.
    for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
    do_load(3, 1'b1, 2, 1'b0);

    repeat (2) @(negedge PHI1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
